shift_engine_mm: RTL and testbench
==================================

// Module: shift_engine_mm
// PURPOSE
//  Memory-mapped, parametrised iterative shift/rotate engine on the peripheral bus (cs/we/reg_sel).
//  CPU writes OPERAND, then CTRL (mode, direction, amount); the write to CTRL starts the operation.
//  The engine shifts STEP bits per clock, then raises done and an optional interrupt.
//  Successor to the fixed 16-bit shifter controller: adds modes, rotate, amounts >= WIDTH, status/IRQ, busy protection.
// PARAMETERS
//  WIDTH  16  operand/bus data width (power of 2, >= 8)
//  STEP   1   bits shifted per clock while running (1..WIDTH, power of 2)
//  AW     $clog2(WIDTH)+1  (localparam) amount field width
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous reset, active-low
//  cs        in   1      chip select
//  we        in   1      write enable, qualified by cs
//  reg_sel   in   2      0=CTRL 1=OPERAND 2=RESULT 3=STATUS
//  data_in   in   WIDTH  write data
//  data_out  out  WIDTH  read data, combinational from reg_sel; 0 when cs=0
//  irq       out  1      done & irq_en, registered
// BEHAVIOUR
//  Reset (reset=0, async): CTRL=0, OPERAND=0, RESULT=0, busy=0, done=0, err=0, irq=0, FSM=IDLE.
//  Write strobe = cs & we, sampled on clk rising edge. Reads have no side effects.
//  CTRL layout: [1:0] mode (00 logical, 01 arithmetic, 10 rotate, 11 = logical), [2] dir (0 left, 1 right),
//   [3] irq_en, [AW+3:4] amount; upper bits read back as 0.
//  Effective amount: logical/arith: min(amount, WIDTH); rotate: amount mod WIDTH.
//  Arithmetic left == logical left. Arithmetic right fills with OPERAND[WIDTH-1].
//  FSM IDLE -> RUN on CTRL write while idle: latch CTRL, work <= OPERAND, cnt <= effective amount,
//   busy=1 from the next cycle, done and err cleared.
//  RUN: each cycle shift work by min(STEP, cnt), cnt -= that; when cnt reaches 0 after that update:
//   RESULT <= work, busy=0, done=1, FSM -> IDLE (same edge).
//  Latency: busy high for max(1, ceil(amt_eff/STEP)) cycles; amount 0 -> one RUN cycle, RESULT = OPERAND.
//  RESULT holds the previous value until the completion edge; no partial results visible.
//  Write to CTRL or OPERAND while busy: ignored, err <= 1. OPERAND write while idle updates OPERAND only.
//  RESULT is read-only; writes to it are ignored without setting err.
//  STATUS read: [0] busy, [1] done, [2] err, rest 0. Any STATUS write clears done and err;
//   if it coincides with completion, completion wins (done=1).
//  irq <= done & irq_en, registered one cycle after done; drops one cycle after done is cleared.
//  Reset mid-RUN aborts immediately; no completion, RESULT=0.
// TESTING
//  W=16,S=1: OPERAND=0x00F1, CTRL logical left amt 4 -> busy 4 cycles, RESULT=0x0F10, done=1.
//  Arithmetic right amt 20 on 0x8000 -> amt_eff 16, RESULT=0xFFFF; logical same -> 0x0000.
//  Rotate right amt 20 on 0x1234 -> amt_eff 4, RESULT=0x4123; amount 0 -> 1 busy cycle, RESULT=0x1234.
//  During RUN write OPERAND=0xAAAA -> err=1, OPERAND unchanged; STATUS write clears err and done.
//  irq_en=1: irq rises 1 cycle after done; STATUS write -> irq low next cycle; W=32,S=4 amt 10 -> 3 cycles.
//  Drive reset low mid-RUN -> all outputs 0 immediately; new CTRL write after release runs normally.

Source files
------------

// File: rtl/shift_engine_mm.sv
// Memory-mapped iterative shift/rotate engine: OPERAND and CTRL are written over the bus,
// the CTRL write starts a multi-cycle shift of STEP bits per clock, and RESULT/STATUS/irq report completion.
module shift_engine_mm #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             we,
  input  logic [1:0]       reg_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             irq
);
  localparam int AW = $clog2(WIDTH) + 1;
  localparam int CW = AW + 4;
  localparam logic [AW-1:0] WMAX  = AW'(WIDTH);
  localparam logic [AW-1:0] SMAX  = AW'(STEP);
  localparam logic [1:0] R_CTRL = 2'd0, R_OPER = 2'd1, R_RES = 2'd2, R_STAT = 2'd3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  op_q, op_d, res_q, res_d, work_q, work_d, shifted;
  logic [AW-1:0]     cnt_q, cnt_d, sh, rot_c, new_amt, eff_amt;
  logic              done_q, done_d, err_q, err_d, irq_q;
  logic              wr, busy;
  logic [1:0]        mode, new_mode;
  logic              dir;

  assign wr       = cs & we;
  assign busy     = (state_q == RUN);
  assign mode     = ctrl_q[1:0];
  assign dir      = ctrl_q[2];
  assign new_mode = data_in[1:0];
  assign new_amt  = data_in[CW-1:4];

  // Rotate wraps the amount; the other modes saturate at WIDTH (everything shifted out).
  always_comb begin
    if (new_mode == 2'b10) eff_amt = {1'b0, new_amt[AW-2:0]};
    else if (new_amt > WMAX) eff_amt = WMAX;
    else eff_amt = new_amt;
  end

  assign sh    = (cnt_q < SMAX) ? cnt_q : SMAX;
  assign rot_c = WMAX - sh;

  always_comb begin
    shifted = work_q;
    if (mode == 2'b10) begin
      // sh == 0 makes the complementary shift equal WIDTH, which yields 0 and leaves work intact
      shifted = dir ? ((work_q >> sh) | (work_q << rot_c))
                    : ((work_q << sh) | (work_q >> rot_c));
    end else if (dir) begin
      if (mode == 2'b01) shifted = WIDTH'($signed(work_q) >>> sh);
      else               shifted = work_q >> sh;
    end else begin
      shifted = work_q << sh;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    op_d    = op_q;
    res_d   = res_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    if (wr && reg_sel == R_STAT) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (wr && reg_sel == R_CTRL) begin
          ctrl_d  = data_in[CW-1:0];
          work_d  = op_q;
          cnt_d   = eff_amt;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = RUN;
        end else if (wr && reg_sel == R_OPER) begin
          op_d = data_in;
        end
      end
      RUN: begin
        if (wr && (reg_sel == R_CTRL || reg_sel == R_OPER)) err_d = 1'b1;
        work_d = shifted;
        cnt_d  = cnt_q - sh;
        // Completion is assigned after the STATUS clear so it wins a same-cycle clear.
        if (cnt_q == sh) begin
          res_d   = shifted;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      op_q    <= '0;
      res_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op_q    <= op_d;
      res_q   <= res_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      irq_q   <= done_q & ctrl_q[3];
    end
  end

  assign irq = irq_q;

  always_comb begin
    data_out = '0;
    if (cs) begin
      case (reg_sel)
        R_CTRL:  data_out = WIDTH'(ctrl_q);
        R_OPER:  data_out = op_q;
        R_RES:   data_out = res_q;
        default: data_out = {{(WIDTH-3){1'b0}}, err_q, done_q, busy};
      endcase
    end
  end
endmodule

// File: tb/tb_shift_engine_mm.sv
// Bench for shift_engine_mm: a transaction-level model checked every cycle, plus literal results
// for the main 16-bit instance and a latency check on a 32-bit, 4-bits-per-clock instance.
module tb_shift_engine_mm;
  localparam int W = 16;
  localparam logic [15:0] CMASK = 16'h01FF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b1, we = 1'b0;
  logic [1:0]  reg_sel = 2'd3;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        irq;

  logic        b_cs = 1'b1, b_we = 1'b0;
  logic [1:0]  b_sel = 2'd3;
  logic [31:0] b_din = '0;
  logic [31:0] b_dout;
  logic        b_irq;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  shift_engine_mm #(.WIDTH(16), .STEP(1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .reg_sel(reg_sel),
    .data_in(data_in), .data_out(data_out), .irq(irq));

  shift_engine_mm #(.WIDTH(32), .STEP(4)) dut32 (
    .clk(clk), .reset(reset), .cs(b_cs), .we(b_we), .reg_sel(b_sel),
    .data_in(b_din), .data_out(b_dout), .irq(b_irq));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-shift result computed bit by bit from the source position.
  function automatic logic [15:0] calc(input logic [15:0] op, input logic [15:0] c);
    int amt, eff, src;
    logic [1:0] md;
    logic rt;
    logic [15:0] r;
    md  = c[1:0];
    rt  = c[2];
    amt = int'(c[8:4]);
    eff = (md == 2'b10) ? amt % W : ((amt > W) ? W : amt);
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (md == 2'b10) begin
        src = rt ? (i + eff) % W : (i - eff + W) % W;
        r[i] = op[src];
      end else if (rt) begin
        src = i + eff;
        r[i] = (src < W) ? op[src] : ((md == 2'b01) ? op[W-1] : 1'b0);
      end else begin
        src = i - eff;
        r[i] = (src >= 0) ? op[src] : 1'b0;
      end
    end
    return r;
  endfunction

  function automatic int lat(input logic [15:0] c);
    int amt, eff;
    amt = int'(c[8:4]);
    eff = (c[1:0] == 2'b10) ? amt % W : ((amt > W) ? W : amt);
    return (eff == 0) ? 1 : eff;
  endfunction

  logic [15:0] m_ctrl = '0, m_op = '0, m_res = '0, m_pend = '0;
  logic        m_busy = 0, m_done = 0, m_err = 0, m_irq = 0;
  int          m_left = 0;

  always @(posedge clk or negedge reset) begin
    logic nd, ne, ni, wrs;
    if (!reset) begin
      m_ctrl = '0; m_op = '0; m_res = '0; m_pend = '0;
      m_busy = 0; m_done = 0; m_err = 0; m_irq = 0; m_left = 0;
    end else begin
      wrs = cs & we;
      ni = m_done & m_ctrl[3];
      nd = m_done;
      ne = m_err;
      if (wrs && reg_sel == 2'd3) begin nd = 0; ne = 0; end
      if (m_busy) begin
        if (wrs && (reg_sel == 2'd0 || reg_sel == 2'd1)) ne = 1;
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_res = m_pend; nd = 1; end
      end else if (wrs && reg_sel == 2'd0) begin
        m_ctrl = data_in & CMASK;
        m_pend = calc(m_op, m_ctrl);
        m_left = lat(m_ctrl);
        m_busy = 1; nd = 0; ne = 0;
      end else if (wrs && reg_sel == 2'd1) begin
        m_op = data_in;
      end
      m_done = nd; m_err = ne; m_irq = ni;
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    e = '0;
    if (cs) begin
      case (reg_sel)
        2'd0: e = m_ctrl;
        2'd1: e = m_op;
        2'd2: e = m_res;
        default: e = {13'b0, m_err, m_done, m_busy};
      endcase
    end
    check("cycle data_out", {16'b0, data_out}, {16'b0, e});
    check("cycle irq", {31'b0, irq}, {31'b0, m_irq});
  end

  // Called at #1 after a rising edge; leaves the bus reading STATUS at #1 after the next edge.
  task automatic wr(input logic [1:0] sel, input logic [15:0] d);
    cs = 1; we = 1; reg_sel = sel; data_in = d;
    @(posedge clk); #1;
    we = 0; reg_sel = 2'd3;
  endtask

  task automatic run(input logic [15:0] c, output int cyc);
    wr(2'd0, c);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_out[0]) cyc++;
      else break;
    end
    if (cyc >= 200) check("run timeout", 32'(cyc), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [15:0] exp, input string name);
    reg_sel = sel;
    @(negedge clk);
    check(name, {16'b0, data_out}, {16'b0, exp});
    @(posedge clk); #1;
    reg_sel = 2'd3;
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check("reset status", {16'b0, data_out}, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);
    reset = 1;
    @(posedge clk); #1;
    rd(2'd2, 16'h0000, "reset result");

    wr(2'd1, 16'h00F1);
    run(16'h0040, cyc);
    check("lsl4 busy cycles", 32'(cyc), 32'd4);
    rd(2'd2, 16'h0F10, "lsl4 result");
    check("model lsl4", {16'b0, m_res}, 32'h0F10);
    rd(2'd3, 16'h0002, "lsl4 status done");

    wr(2'd1, 16'h8000);
    run(16'h0145, cyc);
    check("asr20 busy cycles", 32'(cyc), 32'd16);
    rd(2'd2, 16'hFFFF, "asr20 result");
    check("model asr20", {16'b0, m_res}, 32'hFFFF);
    run(16'h0144, cyc);
    rd(2'd2, 16'h0000, "lsr20 result");

    wr(2'd1, 16'h1234);
    run(16'h0146, cyc);
    check("ror20 busy cycles", 32'(cyc), 32'd4);
    rd(2'd2, 16'h4123, "ror20 result");
    check("model ror20", {16'b0, m_res}, 32'h4123);
    run(16'h0006, cyc);
    check("amt0 busy cycles", 32'(cyc), 32'd1);
    rd(2'd2, 16'h1234, "amt0 result");
    run(16'h0042, cyc);
    rd(2'd2, 16'h2341, "rol4 result");
    run(16'h0043, cyc);
    rd(2'd2, 16'h2340, "mode3 left result");

    wr(2'd0, 16'h0080);
    wr(2'd1, 16'hAAAA);
    wr(2'd0, 16'h0046);
    repeat (10) @(posedge clk);
    #1;
    rd(2'd3, 16'h0006, "busy write err");
    rd(2'd1, 16'h1234, "operand kept");
    rd(2'd2, 16'h3400, "busy-protected result");
    wr(2'd3, 16'h0000);
    rd(2'd3, 16'h0000, "status clear");

    wr(2'd2, 16'hBEEF);
    rd(2'd3, 16'h0000, "result write no err");
    rd(2'd2, 16'h3400, "result write ignored");

    run(16'h0028, cyc);
    check("irq after done", {31'b0, irq}, 32'h1);
    wr(2'd3, 16'h0000);
    check("irq same edge as clear", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq dropped", {31'b0, irq}, 32'h0);

    wr(2'd0, 16'h0010);
    wr(2'd3, 16'h0000);
    rd(2'd3, 16'h0002, "completion beats clear");

    run(16'hFFF0, cyc);
    rd(2'd0, 16'h01F0, "ctrl readback");
    rd(2'd2, 16'h0000, "lsl31 saturates");

    cs = 0;
    @(negedge clk);
    check("cs low reads 0", {16'b0, data_out}, 32'h0);
    @(posedge clk); #1;
    cs = 1;

    wr(2'd0, 16'h0088);
    @(posedge clk); #1;
    reg_sel = 2'd2;
    reset = 0;
    #1;
    check("mid-run reset result", {16'b0, data_out}, 32'h0);
    check("mid-run reset irq", {31'b0, irq}, 32'h0);
    reg_sel = 2'd3;
    #1;
    check("mid-run reset status", {16'b0, data_out}, 32'h0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    wr(2'd1, 16'h00F1);
    run(16'h0040, cyc);
    check("post-reset busy cycles", 32'(cyc), 32'd4);
    rd(2'd2, 16'h0F10, "post-reset result");

    b_we = 1; b_sel = 2'd1; b_din = 32'h1;
    @(posedge clk); #1;
    b_sel = 2'd0; b_din = 32'h000000A0;
    @(posedge clk); #1;
    b_we = 0; b_sel = 2'd3;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_dout[0]) cyc++;
      else break;
    end
    check("w32s4 busy cycles", 32'(cyc), 32'd3);
    check("w32s4 status", b_dout, 32'h2);
    b_sel = 2'd2;
    @(negedge clk);
    check("w32s4 result", b_dout, 32'h400);
    check("w32s4 irq", {31'b0, b_irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
